// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority sound-effect arbiter and note sequencer.
// Accepts one-cycle event pulses (jump, score, crash) and plays the winning
// effect's note list through one shared square-wave tone generator.
`timescale 1ns/1ps

module sfx_scheduler #(
    parameter int NOTE_CYC = 5_000_000, // cycles per note, minimum 2
    parameter int HP_SHIFT = 0          // right shift on every half-period
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       req_jump,
    input  logic       req_score,
    input  logic       req_crash,
    input  logic       mute,
    output logic       ampPWM,
    output logic       ampSD,
    output logic       busy,
    output logic [1:0] active_id
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [22:0] NOTE_LAST = 23'(NOTE_CYC - 1);

    // Unshifted half-period in cycles for note idx of effect id.
    function automatic logic [17:0] note_half_period(input logic [1:0] id,
                                                     input logic [1:0] idx);
        logic [17:0] hp;
        case ({id, idx})
            4'b01_00: hp = 18'd56818;
            4'b01_01: hp = 18'd37922;
            4'b10_00: hp = 18'd47778;
            4'b10_01: hp = 18'd37922;
            4'b10_10: hp = 18'd31888;
            4'b11_00: hp = 18'd113636;
            4'b11_01: hp = 18'd151686;
            4'b11_10: hp = 18'd227273;
            4'b11_11: hp = 18'd227273;
            default:  hp = 18'd0;
        endcase
        return hp;
    endfunction

    // Index of the final note of effect id.
    function automatic logic [1:0] note_last_idx(input logic [1:0] id);
        logic [1:0] last;
        case (id)
            2'd1:    last = 2'd1;
            2'd2:    last = 2'd2;
            2'd3:    last = 2'd3;
            default: last = 2'd0;
        endcase
        return last;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  active_id_q, active_id_d;
    logic [1:0]  note_idx_q, note_idx_d;
    logic [22:0] note_cnt_q, note_cnt_d;
    logic [17:0] hp_cnt_q, hp_cnt_d;
    logic        lvl_q, lvl_d;
    logic        busy_q, busy_d;
    logic        amp_pwm_q, amp_pwm_d;
    logic        amp_sd_q, amp_sd_d;

    logic [1:0]  cand;
    logic        accept;
    logic [17:0] hp_raw;
    logic [17:0] hp_last;
    logic        note_end;
    logic        last_note;

    // Arbitration, acceptance, tone/note sequencing and next output values.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        active_id_d = active_id_q;
        note_idx_d  = note_idx_q;
        note_cnt_d  = note_cnt_q;
        hp_cnt_d    = hp_cnt_q;
        lvl_d       = lvl_q;

        // Highest ID present this cycle wins.
        cand = 2'd0;
        if (req_crash) begin
            cand = 2'd3;
        end else if (req_score) begin
            cand = 2'd2;
        end else if (req_jump) begin
            cand = 2'd1;
        end

        // Equal ID restarts, higher ID preempts, lower ID is dropped.
        accept = (cand != 2'd0) && ((state_q == IDLE) || (cand >= active_id_q));

        // A half-period that shifts down to 0 behaves as 1 (toggle every cycle).
        hp_raw    = note_half_period(active_id_q, note_idx_q) >> HP_SHIFT;
        hp_last   = (hp_raw == 18'd0) ? 18'd0 : hp_raw - 18'd1;
        note_end  = (note_cnt_q == NOTE_LAST);
        last_note = (note_idx_q == note_last_idx(active_id_q));

        if (state_q == PLAY) begin
            if (hp_cnt_q == hp_last) begin
                hp_cnt_d = 18'd0;
                lvl_d    = ~lvl_q;
            end else begin
                hp_cnt_d = hp_cnt_q + 18'd1;
            end

            // Note boundary overrides the tone counter: a partial half-period
            // is truncated and the next note starts high.
            if (note_end) begin
                note_cnt_d = 23'd0;
                hp_cnt_d   = 18'd0;
                if (last_note) begin
                    state_d     = IDLE;
                    active_id_d = 2'd0;
                    note_idx_d  = 2'd0;
                    lvl_d       = 1'b0;
                end else begin
                    note_idx_d = note_idx_q + 2'd1;
                    lvl_d      = 1'b1;
                end
            end else begin
                note_cnt_d = note_cnt_q + 23'd1;
            end
        end

        // An accept wins over everything, including the final note ending.
        if (accept) begin
            state_d     = PLAY;
            active_id_d = cand;
            note_idx_d  = 2'd0;
            note_cnt_d  = 23'd0;
            hp_cnt_d    = 18'd0;
            lvl_d       = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        busy_d    = (state_d == PLAY);
        amp_sd_d  = busy_d & ~mute;
        amp_pwm_d = lvl_d & busy_d & ~mute;
    end

    // State, counters and registered outputs; Reset clears everything at once.
    always_ff @(posedge board_clk or posedge Reset) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (Reset) begin
            state_q     <= IDLE;
            active_id_q <= 2'd0;
            note_idx_q  <= 2'd0;
            note_cnt_q  <= 23'd0;
            hp_cnt_q    <= 18'd0;
            lvl_q       <= 1'b0;
            busy_q      <= 1'b0;
            amp_pwm_q   <= 1'b0;
            amp_sd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
            note_idx_q  <= note_idx_d;
            note_cnt_q  <= note_cnt_d;
            hp_cnt_q    <= hp_cnt_d;
            lvl_q       <= lvl_d;
            busy_q      <= busy_d;
            amp_pwm_q   <= amp_pwm_d;
            amp_sd_q    <= amp_sd_d;
        end
    end

    assign ampPWM    = amp_pwm_q;
    assign ampSD     = amp_sd_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: scenario tasks for sfx_scheduler plus a per-cycle
// scoreboard fed by a closed-form timing model of the effects.
`timescale 1ns/1ps

module tb_sfx_scheduler;

    localparam int NC  = 2000;
    localparam int HPS = 8;

    logic       board_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       req_jump  = 1'b0;
    logic       req_score = 1'b0;
    logic       req_crash = 1'b0;
    logic       mute      = 1'b0;
    logic       ampPWM;
    logic       ampSD;
    logic       busy;
    logic [1:0] active_id;

    int n_checks = 0;
    int n_fail   = 0;

    sfx_scheduler #(.NOTE_CYC(NC), .HP_SHIFT(HPS)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .req_jump  (req_jump),
        .req_score (req_score),
        .req_crash (req_crash),
        .mute      (mute),
        .ampPWM    (ampPWM),
        .ampSD     (ampSD),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 board_clk = ~board_clk;

    // ------------------------------------------------------------------
    // Reference model: expected {busy, active_id, ampPWM, ampSD} after each
    // edge, from "offset since accept" arithmetic rather than counters.
    // ------------------------------------------------------------------
    logic [4:0] exp_q[$];
    int m_id   = 0;
    int m_s    = 0;
    int n_edge = 0;

    function automatic int tbl_hp(input int id, input int idx);
        int raw;
        case (id * 4 + idx)
            4:  raw = 56818;
            5:  raw = 37922;
            8:  raw = 47778;
            9:  raw = 37922;
            10: raw = 31888;
            12: raw = 113636;
            13: raw = 151686;
            14: raw = 227273;
            15: raw = 227273;
            default: raw = 0;
        endcase
        raw = raw >> HPS;
        return (raw == 0) ? 1 : raw;
    endfunction

    function automatic int n_notes(input int id);
        return (id == 0) ? 0 : id + 1;
    endfunction

    task automatic model_step();
        int cand, prev, off, pos, hp;
        logic lvl;
        n_edge++;
        if (Reset) begin
            m_id = 0;
            exp_q.push_back(5'b0);
        end else begin
            prev = (m_id != 0 && (n_edge - 1 - m_s) < n_notes(m_id) * NC) ? m_id : 0;
            cand = req_crash ? 3 : req_score ? 2 : req_jump ? 1 : 0;
            if (cand != 0 && cand >= prev) begin
                m_id = cand;
                m_s  = n_edge;
            end
            off = n_edge - m_s;
            if (m_id != 0 && off < n_notes(m_id) * NC) begin
                pos = off % NC;
                hp  = tbl_hp(m_id, off / NC);
                lvl = ((pos / hp) % 2) == 0;
                exp_q.push_back({1'b1, 2'(m_id), lvl & ~mute, ~mute});
            end else begin
                m_id = 0;
                exp_q.push_back(5'b0);
            end
        end
    endtask

    initial forever begin
        @(posedge board_clk);
        model_step();
    end

    // Scoreboard checker: compares one expectation per cycle on the falling edge.
    initial forever begin
        logic [4:0] e;
        @(negedge board_clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (Reset) e = 5'b0;
            n_checks++;
            if ({busy, active_id, ampPWM, ampSD} !== e) begin
                n_fail++;
                $display("FAIL scoreboard edge %0d: {busy,id,pwm,sd} got %b expected %b",
                         n_edge, {busy, active_id, ampPWM, ampSD}, e);
            end
        end
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: all driving and sampling happens 1 ns after posedge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge board_clk);
        #1;
    endtask

    // Pulse {crash, score, jump} for one cycle; returns at offset 0 of the
    // effect it starts (if accepted).
    task automatic pulse(input logic [2:0] r);
        {req_crash, req_score, req_jump} = r;
        step(1);
        {req_crash, req_score, req_jump} = 3'b000;
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        while (ampPWM === 1'b1 && hi < 4000) begin
            hi++;
            step(1);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        step(3);
        Reset = 1'b0;
        step(5);
        n_checks++;
        if ({busy, active_id, ampPWM, ampSD} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 00000", {busy, active_id, ampPWM, ampSD});
        end
        // Reset mid-crash.
        pulse(3'b100);
        step(500);
        Reset = 1'b1;
        #2;
        n_checks++;
        if ({busy, active_id, ampPWM, ampSD} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected 00000", {busy, active_id, ampPWM, ampSD});
        end
        step(3);
        Reset = 1'b0;
        step(10);
        n_checks++;
        if ({busy, active_id, ampPWM, ampSD} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 00000", {busy, active_id, ampPWM, ampSD});
        end
    endtask

    task automatic test_jump();
        int hi;
        pulse(3'b001);
        n_checks++;
        if ({busy, active_id, ampPWM, ampSD} !== 5'b10111) begin
            n_fail++;
            $display("FAIL jump_start: got %b expected 10111", {busy, active_id, ampPWM, ampSD});
        end
        count_high(hi);
        n_checks++;
        if (hi !== 221) begin
            n_fail++;
            $display("FAIL jump_note0_high: got %0d expected 221", hi);
        end
        step(NC - 221);
        count_high(hi);
        n_checks++;
        if (hi !== 148) begin
            n_fail++;
            $display("FAIL jump_note1_high: got %0d expected 148", hi);
        end
        step(2 * NC - 1 - (NC + 148));
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_last_cycle_busy: got %b expected 1", busy);
        end
        step(1);
        n_checks++;
        if ({busy, active_id} !== 3'b000) begin
            n_fail++;
            $display("FAIL jump_end: got %b expected 000", {busy, active_id});
        end
    endtask

    task automatic test_simultaneous();
        int hi;
        pulse(3'b111);
        n_checks++;
        if (active_id !== 2'd3) begin
            n_fail++;
            $display("FAIL simul_id: got %0d expected 3", active_id);
        end
        count_high(hi);
        n_checks++;
        if (hi !== 443) begin
            n_fail++;
            $display("FAIL simul_high: got %0d expected 443", hi);
        end
        step(4 * NC - 1 - 443);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_last_cycle_busy: got %b expected 1", busy);
        end
        step(1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_preempt_drop();
        int n;
        pulse(3'b010);
        step(NC + 50);
        pulse(3'b100);
        n_checks++;
        if ({busy, active_id, ampPWM} !== 4'b1111) begin
            n_fail++;
            $display("FAIL preempt: got %b expected 1111", {busy, active_id, ampPWM});
        end
        step(100);
        pulse(3'b001);
        n_checks++;
        if (active_id !== 2'd3) begin
            n_fail++;
            $display("FAIL drop_lower: got %0d expected 3", active_id);
        end
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            step(1);
            n++;
        end
        n_checks++;
        if (n !== 4 * NC - 101) begin
            n_fail++;
            $display("FAIL preempt_len: got %0d expected %0d", n, 4 * NC - 101);
        end
    endtask

    task automatic test_restart();
        int hi;
        pulse(3'b010);
        step(2 * NC + 300);
        pulse(3'b010);
        n_checks++;
        if ({busy, active_id, ampPWM} !== 4'b1101) begin
            n_fail++;
            $display("FAIL restart: got %b expected 1101", {busy, active_id, ampPWM});
        end
        count_high(hi);
        n_checks++;
        if (hi !== 186) begin
            n_fail++;
            $display("FAIL restart_note0_high: got %0d expected 186", hi);
        end
        step(3 * NC - 1 - 186);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_last_cycle_busy: got %b expected 1", busy);
        end
        step(1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_mute();
        pulse(3'b001);
        mute = 1'b1;
        step(1);
        n_checks++;
        if ({busy, ampPWM, ampSD} !== 3'b100) begin
            n_fail++;
            $display("FAIL mute_on: got %b expected 100", {busy, ampPWM, ampSD});
        end
        step(449);
        mute = 1'b0;
        step(1);
        n_checks++;
        if ({ampPWM, ampSD} !== 2'b11) begin
            n_fail++;
            $display("FAIL mute_off_phase_high: got %b expected 11", {ampPWM, ampSD});
        end
        step(212);
        n_checks++;
        if ({ampPWM, ampSD} !== 2'b01) begin
            n_fail++;
            $display("FAIL mute_off_phase_low: got %b expected 01", {ampPWM, ampSD});
        end
        step(2 * NC - 663);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mute_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        pulse(3'b001);
        step(2 * NC - 1);
        pulse(3'b010);
        n_checks++;
        if ({busy, active_id, ampPWM} !== 4'b1101) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got %b expected 1101", {busy, active_id, ampPWM});
        end
        step(3 * NC - 1);
        pulse(3'b001);
        n_checks++;
        if ({busy, active_id} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_lower_dropped_at_end: got %b expected 000", {busy, active_id});
        end
        step(3);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_simultaneous();
        test_preempt_drop();
        test_restart();
        test_mute();
        test_back_to_back();
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
